// File: rtl/sad_pkg.sv
// Shared types, sizes and helpers for the SAD window comparator.
package sad_pkg;

    localparam int PIX_W  = 8;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ADDR_W = 8;
    localparam int SAD_W  = PIX_W + 4;
    localparam int CSUM_W = PIX_W + 2;
    localparam int WORD_W = ROWS * PIX_W;

    typedef logic [1:0] phase_t;

    // Extract pixel 'row' from a packed column word (row 0 in the LSBs).
    function automatic logic [PIX_W-1:0] get_pix(input logic [WORD_W-1:0] word, input int row);
        return word[row*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/sad_col_absdiff.sv
// One window column: absolute difference of each pixel against the template
// column, summed into a column partial SAD.
module sad_col_absdiff
    import sad_pkg::*;
(
    input  logic [WORD_W-1:0] pix,
    input  logic [WORD_W-1:0] tmpl,
    output logic [CSUM_W-1:0] col_sum
);

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Accumulate the per-row absolute differences of this column.
    always_comb begin
        col_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            col_sum = col_sum + CSUM_W'(absdiff(get_pix(pix, r), get_pix(tmpl, r)));
        end
    end

endmodule

// File: rtl/sad_window_compare.sv
// SAD window comparator: reads four frame-memory columns in lock-step with the
// column-address generator, computes the 4x4 SAD against a stored template and
// tracks the best (lowest) SAD and its window address.
// Optional feature: define SAD_THRESH_EN to add sad_thresh / sad_hit.
module sad_window_compare
    import sad_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                On,
    input  logic [ADDR_W-1:0]   AddressC1,
    input  logic [ADDR_W-1:0]   AddressC2,
    input  logic [ADDR_W-1:0]   AddressC3,
    input  logic [ADDR_W-1:0]   AddressC4,
    input  logic                tmpl_we,
    input  logic [1:0]          tmpl_col,
    input  logic [WORD_W-1:0]   tmpl_data,
    input  logic                clr_min,
`ifdef SAD_THRESH_EN
    input  logic [SAD_W-1:0]    sad_thresh,
    output logic                sad_hit,
`endif
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [WORD_W-1:0]   mem_data,
    output logic                sad_valid,
    output logic [SAD_W-1:0]    sad_out,
    output logic [ADDR_W-1:0]   win_addr,
    output logic [SAD_W-1:0]    min_sad,
    output logic [ADDR_W-1:0]   min_addr
);

    phase_t             phase;
    phase_t             rd_phase;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  issue_tag;
    logic [WORD_W-1:0]  col_buf  [COLS];
    logic [WORD_W-1:0]  tmpl_mem [COLS];
    logic               win_valid;
    logic [ADDR_W-1:0]  win_tag;
    logic [CSUM_W-1:0]  col_sum  [COLS];
    logic [CSUM_W-1:0]  s1_sum   [COLS];
    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_tag;
    logic [SAD_W-1:0]   total;

    // Pick the generator address that belongs to the current phase.
    always_comb begin
        case (phase)
            2'd0:    sel_addr = AddressC1;
            2'd1:    sel_addr = AddressC2;
            2'd2:    sel_addr = AddressC3;
            default: sel_addr = AddressC4;
        endcase
    end

    // Issue one read per On cycle and advance the phase; phase 0 opens a new window tag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase     <= '0;
            rd_phase  <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            issue_tag <= '0;
        end else if (On) begin
            mem_rd   <= 1'b1;
            mem_addr <= sel_addr;
            rd_phase <= phase;
            phase    <= phase_t'(phase + 2'd1);
            if (phase == 2'd0) begin
                issue_tag <= AddressC1;
            end
        end else begin
            mem_rd <= 1'b0;
        end
    end

    // Capture returning column data; the phase-3 column completes the window.
    // Stage 1 samples col_buf on the very next edge, before any new phase-0
    // capture can overwrite column 0, so col_buf itself serves as the snapshot.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                col_buf[c] <= '0;
            end
            win_valid <= 1'b0;
            win_tag   <= '0;
        end else begin
            win_valid <= mem_rd && (rd_phase == 2'd3);
            if (mem_rd) begin
                col_buf[rd_phase] <= mem_data;
                if (rd_phase == 2'd3) begin
                    win_tag <= issue_tag;
                end
            end
        end
    end

    // Template columns are only writable while the pipeline is not issuing.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                tmpl_mem[c] <= '0;
            end
        end else if (tmpl_we && !On) begin
            tmpl_mem[tmpl_col] <= tmpl_data;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        sad_col_absdiff u_col (
            .pix     (col_buf[c]),
            .tmpl    (tmpl_mem[c]),
            .col_sum (col_sum[c])
        );
    end

    // Stage 1: register the four column partial sums of a completed window.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                s1_sum[c] <= '0;
            end
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= win_valid;
            if (win_valid) begin
                for (int c = 0; c < COLS; c++) begin
                    s1_sum[c] <= col_sum[c];
                end
                s1_tag <= win_tag;
            end
        end
    end

    // Add the column partial sums into the window SAD.
    always_comb begin
        total = '0;
        for (int c = 0; c < COLS; c++) begin
            total = total + SAD_W'(s1_sum[c]);
        end
    end

    // Stage 2: publish the window SAD with its tag as a one-cycle pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sad_valid <= 1'b0;
            sad_out   <= '0;
            win_addr  <= '0;
        end else begin
            sad_valid <= s1_valid;
            if (s1_valid) begin
                sad_out  <= total;
                win_addr <= s1_tag;
            end
        end
    end

`ifdef SAD_THRESH_EN
    // Flag windows at or below the threshold, aligned with sad_valid.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sad_hit <= 1'b0;
        end else begin
            sad_hit <= s1_valid && (total <= sad_thresh);
        end
    end
`endif

    // Track the lowest SAD; ties keep the earlier window, clr_min restarts the search.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            min_sad  <= '1;
            min_addr <= '0;
        end else if (clr_min) begin
            if (sad_valid) begin
                min_sad  <= sad_out;
                min_addr <= win_addr;
            end else begin
                min_sad  <= '1;
                min_addr <= '0;
            end
        end else if (sad_valid && (sad_out < min_sad)) begin
            min_sad  <= sad_out;
            min_addr <= win_addr;
        end
    end

endmodule

// File: tb/tb_sad_window_compare.sv
// Self-checking bench for sad_window_compare: randomized and directed windows
// checked against a whole-window SAD reference model and scoreboard.
// Define SAD_THRESH_EN to also check sad_hit.
module tb_sad_window_compare;

    logic        Clk;
    logic        Rst_n;
    logic        On;
    logic [7:0]  AddressC1, AddressC2, AddressC3, AddressC4;
    logic        tmpl_we;
    logic [1:0]  tmpl_col;
    logic [31:0] tmpl_data;
    logic        clr_min;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        sad_valid;
    logic [11:0] sad_out;
    logic [7:0]  win_addr;
    logic [11:0] min_sad;
    logic [7:0]  min_addr;
`ifdef SAD_THRESH_EN
    logic [11:0] sad_thresh;
    logic        sad_hit;
`endif

    sad_window_compare dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .On        (On),
        .AddressC1 (AddressC1),
        .AddressC2 (AddressC2),
        .AddressC3 (AddressC3),
        .AddressC4 (AddressC4),
        .tmpl_we   (tmpl_we),
        .tmpl_col  (tmpl_col),
        .tmpl_data (tmpl_data),
        .clr_min   (clr_min),
`ifdef SAD_THRESH_EN
        .sad_thresh(sad_thresh),
        .sad_hit   (sad_hit),
`endif
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .sad_valid (sad_valid),
        .sad_out   (sad_out),
        .win_addr  (win_addr),
        .min_sad   (min_sad),
        .min_addr  (min_addr)
    );

    typedef struct {
        logic [11:0] sad;
        logic [7:0]  tag;
        int          due;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nvalid = 0;
    bit [31:0]   mem [256];
    bit [31:0]   tmpl_m [4];
    logic [7:0]  cur_addr [4];
    logic [7:0]  cur_tag;
    int          mph = 0;
    logic        exp_rd = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [11:0] mmin = 12'hFFF;
    logic [7:0]  maddr = '0;
    exp_t        expq [$];
    exp_t        mon_e;
    bit          have;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc = cyc + 1;

    // Frame memory: data for a read is presented during the cycle after mem_rd.
    always @(posedge Clk) begin
        #1;
        mem_data = mem_rd ? mem[mem_addr] : $urandom;
    end

    // Whole-window SAD from the model memory and model template.
    function automatic int calc_sad();
        int s = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int p = int'((mem[cur_addr[c]] >> (8 * r)) & 32'hFF);
                int t = int'((tmpl_m[c] >> (8 * r)) & 32'hFF);
                s += (p > t) ? (p - t) : (t - p);
            end
        end
        return s;
    endfunction

    // Monitor: read strobes, scoreboard of windows, and running minimum.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1) begin
            total++;
            if (mem_rd !== exp_rd) begin
                bad++;
                $display("[TB] FAIL mem_rd cyc=%0d got=%b exp=%b", cyc, mem_rd, exp_rd);
            end
            if (exp_rd) begin
                total++;
                if (mem_addr !== exp_addr) begin
                    bad++;
                    $display("[TB] FAIL mem_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr, exp_addr);
                end
            end
            total++;
            if (min_sad !== mmin || min_addr !== maddr) begin
                bad++;
                $display("[TB] FAIL min cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, min_sad, min_addr, mmin, maddr);
            end
            have = 1'b0;
            if (sad_valid === 1'b1) begin
                nvalid++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sad_valid_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    have = 1'b1;
                    if (sad_out !== mon_e.sad || win_addr !== mon_e.tag) begin
                        bad++;
                        $display("[TB] FAIL window cyc=%0d got sad=%0d tag=%0d exp sad=%0d tag=%0d",
                                 cyc, sad_out, win_addr, mon_e.sad, mon_e.tag);
                    end
                    total++;
                    if (cyc != mon_e.due) begin
                        bad++;
                        $display("[TB] FAIL latency got cyc=%0d exp cyc=%0d", cyc, mon_e.due);
                    end
                end
            end else if (expq.size() > 0 && expq[0].due < cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL sad_valid_missing cyc=%0d got=0 exp=1", cyc);
                void'(expq.pop_front());
            end
`ifdef SAD_THRESH_EN
            total++;
            if (sad_hit !== (have && (mon_e.sad <= sad_thresh))) begin
                bad++;
                $display("[TB] FAIL sad_hit cyc=%0d got=%b", cyc, sad_hit);
            end
`endif
            if (clr_min === 1'b1) begin
                if (have) begin
                    mmin  = mon_e.sad;
                    maddr = mon_e.tag;
                end else begin
                    mmin  = 12'hFFF;
                    maddr = '0;
                end
            end else if (have && (mon_e.sad < mmin)) begin
                mmin  = mon_e.sad;
                maddr = mon_e.tag;
            end
        end else begin
            mmin  = 12'hFFF;
            maddr = '0;
        end
    end

    // One clock of stimulus; updates the issue/window model for this edge.
    task automatic step(input logic on, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] a3, input logic [7:0] a4, input logic clr,
                        input logic we, input logic [1:0] col, input logic [31:0] data);
        logic [7:0] sel;
        On = on;
        AddressC1 = a1;
        AddressC2 = a2;
        AddressC3 = a3;
        AddressC4 = a4;
        clr_min = clr;
        tmpl_we = we;
        tmpl_col = col;
        tmpl_data = data;
        sel = (mph == 0) ? a1 : (mph == 1) ? a2 : (mph == 2) ? a3 : a4;
        if (on) begin
            if (mph == 0) cur_tag = a1;
            cur_addr[mph] = sel;
        end
        @(posedge Clk);
        #1;
        if (Rst_n) begin
            if (we && !on) tmpl_m[col] = data;
            exp_rd = on;
            if (on) begin
                exp_addr = sel;
                if (mph == 3) expq.push_back('{sad: 12'(calc_sad()), tag: cur_tag, due: cyc + 3});
                mph = (mph + 1) % 4;
            end
        end
        clr_min = 1'b0;
        tmpl_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic issue(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
        step(1'b1, a1, a2, a3, a4, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic issue_rand(input int n);
        for (int i = 0; i < n; i++) issue(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic write_tmpl_all(input logic [31:0] w);
        for (int c = 0; c < 4; c++) step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 2'(c), w);
    endtask

    task automatic pulse_clr();
        step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 2'd0, 32'd0);
    endtask

    // Wait for every expected window to appear, bounded.
    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 30) begin
            idle(1);
            n++;
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending got=%0d exp=0", expq.size());
            expq.delete();
        end
        idle(2);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        On = 1'b0;
        expq.delete();
        mph = 0;
        exp_rd = 1'b0;
        for (int c = 0; c < 4; c++) tmpl_m[c] = '0;
        #1;
        total++;
        if (mem_rd !== 1'b0 || mem_addr !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_rd got=%b/%0d exp=0/0", mem_rd, mem_addr);
        end
        total++;
        if (sad_valid !== 1'b0 || sad_out !== 12'd0 || win_addr !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_sad got=%b/%0d/%0d exp=0/0/0", sad_valid, sad_out, win_addr);
        end
        total++;
        if (min_sad !== 12'hFFF || min_addr !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_min got=%0d/%0d exp=4095/0", min_sad, min_addr);
        end
`ifdef SAD_THRESH_EN
        total++;
        if (sad_hit !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hit got=%b exp=0", sad_hit);
        end
`endif
        idle(2);
        Rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_uniform();
        int v0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h10101010;
        write_tmpl_all(32'h10101010);
        v0 = nvalid;
        issue_rand(8);
        drain();
        total++;
        if (nvalid - v0 != 2 || sad_out !== 12'd0) begin
            bad++;
            $display("[TB] FAIL uniform got n=%0d sad=%0d exp n=2 sad=0", nvalid - v0, sad_out);
        end
    endtask

    task automatic test_max();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFFFFFF;
        write_tmpl_all(32'h0);
        pulse_clr();
        issue_rand(4);
        drain();
        total++;
        if (sad_out !== 12'd4080 || min_sad !== 12'd4080) begin
            bad++;
            $display("[TB] FAIL max got sad=%0d min=%0d exp 4080/4080", sad_out, min_sad);
        end
    endtask

    task automatic test_min_ties();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[10] = 32'd50;
        mem[11] = 32'd20;
        mem[12] = 32'h00000200 | 32'd18;
        mem[13] = 32'd35;
        pulse_clr();
        for (int w = 0; w < 4; w++) begin
            issue(8'(10 + w), 8'd99, 8'd99, 8'd99);
            issue(8'd99, 8'd0, 8'd99, 8'd99);
            issue(8'd99, 8'd99, 8'd0, 8'd99);
            issue(8'd99, 8'd99, 8'd99, 8'd0);
        end
        drain();
        total++;
        if (min_sad !== 12'd20 || min_addr !== 8'd11) begin
            bad++;
            $display("[TB] FAIL min_ties got=%0d/%0d exp=20/11", min_sad, min_addr);
        end
    endtask

    task automatic test_on_gap();
        int v0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        v0 = nvalid;
        issue_rand(2);
        idle(5);
        issue_rand(2);
        drain();
        total++;
        if (nvalid - v0 != 1) begin
            bad++;
            $display("[TB] FAIL on_gap windows got=%0d exp=1", nvalid - v0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        issue_rand(2);
        idle(1);
        do_reset();
        v0 = nvalid;
        issue_rand(3);
        idle(5);
        issue_rand(1);
        drain();
        total++;
        if (nvalid - v0 != 1) begin
            bad++;
            $display("[TB] FAIL reset_mid windows got=%0d exp=1", nvalid - v0);
        end
    endtask

    task automatic test_clr_coincident();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[20] = 32'h00002DFF;
        mem[21] = 32'd10;
        write_tmpl_all(32'h0);
        pulse_clr();
        issue(8'd21, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        idle(4);
        issue(8'd20, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        issue(8'd0, 8'd0, 8'd0, 8'd0);
        idle(3);
        pulse_clr();
        drain();
        total++;
        if (min_sad !== 12'd300 || min_addr !== 8'd20) begin
            bad++;
            $display("[TB] FAIL clr_coincident got=%0d/%0d exp=300/20", min_sad, min_addr);
        end
    endtask

    task automatic test_random();
        logic on;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int c = 0; c < 4; c++) step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 2'(c), $urandom);
        pulse_clr();
        for (int i = 0; i < 80; i++) begin
            on = ($urandom_range(0, 3) != 0);
            step(on, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 9) == 0), on && ($urandom_range(0, 4) == 0),
                 2'($urandom), $urandom);
        end
        drain();
    endtask

    initial begin
        Rst_n = 1'b0;
        On = 1'b0;
        AddressC1 = '0;
        AddressC2 = '0;
        AddressC3 = '0;
        AddressC4 = '0;
        tmpl_we = 1'b0;
        tmpl_col = '0;
        tmpl_data = '0;
        clr_min = 1'b0;
        mem_data = '0;
`ifdef SAD_THRESH_EN
        sad_thresh = 12'd20;
`endif
        @(posedge Clk);
        #1;
        test_reset();
        test_uniform();
        test_max();
        test_min_ties();
        test_on_gap();
        test_reset_mid();
        test_clr_coincident();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
